fetch_stage: RTL



---
 rtl/fetch_stage_pkg.sv | 25 ++
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_skid_buf.sv | 41 ++++
 rtl/fetch_stage.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// fetch constants and small PC helpers.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FET_BOOT  = 2'd0,
        FET_RUN   = 2'd1,
        FET_STALL = 2'd2,
        FET_DROP  = 2'd3
    } fet_state_e;

    localparam logic [31:0] FET_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] FET_NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'h0000_0004;

    // Redirect targets are word addresses; the byte offset is discarded.
    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] next_pc(input logic [31:0] a);
        return a + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and
// instruction memory (slave).
interface fetch_stage_if;
    logic        o_FET_imemReq;
    logic [31:0] o_FET_imemAddr;
    logic        i_FET_imemAck;
    logic [31:0] i_FET_imemRData;

    modport master (
        output o_FET_imemReq,
        output o_FET_imemAddr,
        input  i_FET_imemAck,
        input  i_FET_imemRData
    );

    modport slave (
        input  o_FET_imemReq,
        input  o_FET_imemAddr,
        output i_FET_imemAck,
        output i_FET_imemRData
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, inst} holding register that parks an instruction which
// arrived from memory while decode was paused.
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        load,
    input  logic        clear,
    input  logic        unload,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_inst,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        full
);

    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic        full_r;

    // Entry storage; clear and unload both empty it and win over load.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_r   <= 32'h0000_0000;
            inst_r <= FET_NOP_INST;
            full_r <= 1'b0;
        end else if (clear || unload) begin
            full_r <= 1'b0;
        end else if (load) begin
            pc_r   <= load_pc;
            inst_r <= load_inst;
            full_r <= 1'b1;
        end
    end

    assign pc   = pc_r;
    assign inst = inst_r;
    assign full = full_r;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the fetch PC, runs the single-outstanding
// imem handshake and drives the IF/ID payload with pause and redirect handling.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FET_RESET_PC,
    parameter logic [31:0] NOP_INST = FET_NOP_INST
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_FET_pause,
    input  logic               i_FET_redirect,
    input  logic [31:0]        i_FET_redirectPC,
    fetch_stage_if.master      imem,
    output logic [31:0]        o_FET_PC,
    output logic [31:0]        o_FET_inst,
    output logic               o_FET_valid
);

    fet_state_e  state_r;
    logic [31:0] fpc_r;
    logic        req_r;
    logic [31:0] addr_r;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic        valid_r;

    logic [31:0] rpc_s;
    logic [31:0] fpc_inc_s;
    logic        ack_s;
    logic        skid_load_s;
    logic        skid_clear_s;
    logic        skid_unload_s;
    logic [31:0] skid_pc_s;
    logic [31:0] skid_inst_s;
    logic        skid_full_s;

    assign rpc_s     = align_pc(i_FET_redirectPC);
    assign fpc_inc_s = next_pc(fpc_r);
    assign ack_s     = imem.i_FET_imemAck;

    // Skid control: park on ack-under-pause, drop on redirect, drain on release.
    always_comb begin
        skid_load_s   = 1'b0;
        skid_clear_s  = 1'b0;
        skid_unload_s = 1'b0;
        if ((state_r == FET_RUN) && !i_FET_redirect && ack_s && i_FET_pause) begin
            skid_load_s = 1'b1;
        end else if ((state_r == FET_STALL) && i_FET_redirect) begin
            skid_clear_s = 1'b1;
        end else if ((state_r == FET_STALL) && !i_FET_pause) begin
            skid_unload_s = 1'b1;
        end else begin
            skid_load_s = 1'b0;
        end
    end

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .load      (skid_load_s),
        .clear     (skid_clear_s),
        .unload    (skid_unload_s),
        .load_pc   (fpc_r),
        .load_inst (imem.i_FET_imemRData),
        .pc        (skid_pc_s),
        .inst      (skid_inst_s),
        .full      (skid_full_s)
    );

    // Fetch FSM with PC, request and IF/ID output registers. In RUN addr_r
    // always equals fpc_r; in DROP addr_r keeps the abandoned address.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= FET_BOOT;
            fpc_r   <= RESET_PC;
            req_r   <= 1'b0;
            addr_r  <= RESET_PC;
            pc_r    <= 32'h0000_0000;
            inst_r  <= NOP_INST;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                FET_BOOT: begin
                    state_r <= FET_RUN;
                    req_r   <= 1'b1;
                    if (i_FET_redirect) begin
                        fpc_r  <= rpc_s;
                        addr_r <= rpc_s;
                    end
                end
                FET_RUN: begin
                    if (i_FET_redirect) begin
                        fpc_r   <= rpc_s;
                        valid_r <= 1'b0;
                        inst_r  <= NOP_INST;
                        if (ack_s) begin
                            addr_r <= rpc_s;
                        end else begin
                            state_r <= FET_DROP;
                        end
                    end else if (ack_s) begin
                        fpc_r  <= fpc_inc_s;
                        addr_r <= fpc_inc_s;
                        if (i_FET_pause) begin
                            state_r <= FET_STALL;
                            req_r   <= 1'b0;
                        end else begin
                            pc_r    <= fpc_r;
                            inst_r  <= imem.i_FET_imemRData;
                            valid_r <= 1'b1;
                        end
                    end else if (!i_FET_pause) begin
                        valid_r <= 1'b0;
                        inst_r  <= NOP_INST;
                    end
                end
                FET_STALL: begin
                    if (i_FET_redirect) begin
                        fpc_r   <= rpc_s;
                        addr_r  <= rpc_s;
                        valid_r <= 1'b0;
                        inst_r  <= NOP_INST;
                        req_r   <= 1'b1;
                        state_r <= FET_RUN;
                    end else if (!i_FET_pause && skid_full_s) begin
                        pc_r    <= skid_pc_s;
                        inst_r  <= skid_inst_s;
                        valid_r <= 1'b1;
                        req_r   <= 1'b1;
                        state_r <= FET_RUN;
                    end
                end
                FET_DROP: begin
                    if (i_FET_redirect) begin
                        fpc_r <= rpc_s;
                    end
                    if (ack_s) begin
                        addr_r  <= i_FET_redirect ? rpc_s : fpc_r;
                        state_r <= FET_RUN;
                    end
                end
                default: begin
                    state_r <= FET_BOOT;
                    req_r   <= 1'b0;
                    valid_r <= 1'b0;
                    inst_r  <= NOP_INST;
                end
            endcase
        end
    end

    assign imem.o_FET_imemReq  = req_r;
    assign imem.o_FET_imemAddr = addr_r;
    assign o_FET_PC            = pc_r;
    assign o_FET_inst          = inst_r;
    assign o_FET_valid         = valid_r;

endmodule
